// File: rtl/iir_sos_cascade.sv
// Cascade of Nsec Direct Form I biquads sharing one time-multiplexed MAC, with a run-time coefficient bank.
// Optional macro IIR_SOS_SATURATE_EN: clamp section outputs and flag ovf; otherwise outputs wrap.
module iir_sos_cascade #(
    parameter int Ndint  = 3,
    parameter int Ndfrac = 22,
    parameter int Ncint  = 4,
    parameter int Ncfrac = 14,
    parameter int Nsec   = 2,
    parameter int Nguard = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dv_in,
    input  logic [Ndint+Ndfrac-1:0]      d_in,
    output logic                         in_ready,
    output logic                         dv_out,
    output logic [Ndint+Ndfrac-1:0]      d_out,
    input  logic                         coef_we,
    input  logic [$clog2(5*Nsec)-1:0]    coef_addr,
    input  logic [Ncint+Ncfrac-1:0]      coef_data,
    output logic                         overrun,
    output logic                         ovf
);

    localparam int ND    = Ndint + Ndfrac;
    localparam int NC    = Ncint + Ncfrac;
    localparam int NP    = ND + NC;
    localparam int NA    = NP + Nguard;
    localparam int NCOEF = 5 * Nsec;
    localparam int AW    = $clog2(NCOEF);
    localparam int SW    = (Nsec > 1) ? $clog2(Nsec) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic signed [NC-1:0] coef [NCOEF];
    logic signed [ND-1:0] x1 [Nsec];
    logic signed [ND-1:0] x2 [Nsec];
    logic signed [ND-1:0] y1 [Nsec];
    logic signed [ND-1:0] y2 [Nsec];
    logic signed [ND-1:0] xin;
    logic [SW-1:0]        s;
    logic [2:0]           k;
    logic signed [NA-1:0] acc;

    logic [AW-1:0]        cidx;
    logic signed [NC-1:0] c_sel;
    logic signed [ND-1:0] d_sel;
    logic signed [NP-1:0] prod;
    logic signed [NA-1:0] acc_base;
    logic signed [NA-1:0] acc_next;
    logic signed [ND-1:0] ynew;
    logic                 sat_hit;
    logic                 last_sec;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (dv_in) state_next = MAC;
            end
            MAC:  if (k == 3'd4) state_next = FIN;
            FIN:  state_next = last_sec ? DONE : MAC;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- MAC datapath ----------------
    always_comb begin
        last_sec = (s == SW'(Nsec - 1));
        cidx     = AW'(s) * AW'(5) + AW'(k);
        c_sel    = coef[cidx];
        case (k)
            3'd0:    d_sel = xin;
            3'd1:    d_sel = x1[s];
            3'd2:    d_sel = x2[s];
            3'd3:    d_sel = y1[s];
            default: d_sel = y2[s];
        endcase
        prod     = NP'(c_sel) * NP'(d_sel);
        acc_base = (k == 3'd0) ? '0 : acc;
        // feedback terms enter negated since a0 is implied 1 on the output side
        if (k >= 3'd3) acc_next = acc_base - NA'(prod);
        else           acc_next = acc_base + NA'(prod);
    end

`ifdef IIR_SOS_SATURATE_EN
    logic [NA-Ncfrac-ND:0] acc_top;

    always_comb begin
        acc_top = acc[NA-1:Ncfrac+ND-1];
        sat_hit = !((&acc_top) || !(|acc_top));
        if (!sat_hit)       ynew = acc[Ncfrac +: ND];
        else if (acc[NA-1]) ynew = {1'b1, {(ND-1){1'b0}}};
        else                ynew = {1'b0, {(ND-1){1'b1}}};
    end
`else
    always_comb begin
        sat_hit = 1'b0;
        ynew    = acc[Ncfrac +: ND];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            dv_out  <= 1'b0;
            d_out   <= '0;
            overrun <= 1'b0;
            xin     <= '0;
            s       <= '0;
            k       <= '0;
            acc     <= '0;
            for (int unsigned i = 0; i < Nsec; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
            for (int unsigned i = 0; i < NCOEF; i++)
                coef[i] <= (i % 5 == 0) ? NC'(1 << Ncfrac) : '0;
        end else begin
            dv_out <= 1'b0;
            if (coef_we && state == IDLE && coef_addr < AW'(NCOEF))
                coef[coef_addr] <= coef_data;
            if (dv_in && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (dv_in) begin
                        xin <= d_in;
                        s   <= '0;
                        k   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= k + 3'd1;
                end
                FIN: begin
                    x2[s] <= x1[s];
                    x1[s] <= xin;
                    y2[s] <= y1[s];
                    y1[s] <= ynew;
                    xin   <= ynew;
                    k     <= '0;
                    if (last_sec) d_out <= ynew;
                    else          s     <= s + 1'b1;
                end
                DONE: dv_out <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef IIR_SOS_SATURATE_EN
    always_ff @(posedge clk) begin
        if (reset)                       ovf <= 1'b0;
        else if (state == FIN && sat_hit) ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_iir_sos_cascade.sv
// Directed bench for iir_sos_cascade (Nsec=2): latency, gain, feedback, overflow, overrun, reset abort.
module tb_iir_sos_cascade;

    localparam int ND = 25;
    localparam int NC = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          dv_in;
    logic [ND-1:0] d_in;
    logic          in_ready;
    logic          dv_out;
    logic [ND-1:0] d_out;
    logic          coef_we;
    logic [3:0]    coef_addr;
    logic [NC-1:0] coef_data;
    logic          overrun;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    iir_sos_cascade #(
        .Ndint(3), .Ndfrac(22), .Ncint(4), .Ncfrac(14), .Nsec(2), .Nguard(3)
    ) dut (
        .clk(clk), .reset(reset), .dv_in(dv_in), .d_in(d_in),
        .in_ready(in_ready), .dv_out(dv_out), .d_out(d_out),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .overrun(overrun), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [NC-1:0] v);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = v;
        tick();
        coef_we   = 1'b0;
    endtask

    // Returns the output sample, edges from accept to dv_out, and cycles with in_ready low.
    task automatic send(input logic [ND-1:0] x, output logic [ND-1:0] y,
                        output int lat, output int low);
        d_in  = x;
        dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
        low   = in_ready ? 0 : 1;
        lat   = 0;
        y     = 'x;
        for (int i = 0; i < 100; i++) begin
            tick();
            lat++;
            if (dv_out) begin
                y = d_out;
                break;
            end
            if (!in_ready) low++;
        end
    endtask

    logic [ND-1:0] y;
    logic [ND-1:0] cap;
    int lat, low, pulses;

    initial begin
        reset = 1'b1; dv_in = 1'b0; d_in = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_dv_out", dv_out, 0);
        check("rst_d_out", d_out, 0);
        check("rst_overrun", overrun, 0);
        check("rst_ovf", ovf, 0);

        // passthrough after reset
        send(25'h0400000, y, lat, low);
        check("pass_out", y, 32'h0400000);
        check("pass_latency", lat, 13);
        check("pass_ready_low", low, 13);
        tick();
        check("pass_pulse_width", dv_out, 0);
        check("pass_hold", d_out, 32'h0400000);

        // two half-gain sections
        write_coef(4'd0, 18'h02000);
        write_coef(4'd5, 18'h02000);
        send(25'h0400000, y, lat, low);
        check("gain_quarter", y, 32'h0100000);

        // first-order feedback y = x + 0.5*y1
        do_reset();
        write_coef(4'd3, 18'h3E000);
        send(25'h0400000, y, lat, low);
        check("step_1", y, 32'h0400000);
        send(25'h0400000, y, lat, low);
        check("step_2", y, 32'h0600000);
        send(25'h0400000, y, lat, low);
        check("step_3", y, 32'h0700000);

        // out-of-range output of section 0
        do_reset();
        write_coef(4'd0, 18'h1C000);
        send(25'h0400000, y, lat, low);
`ifdef IIR_SOS_SATURATE_EN
        check("ovf_out", y, 32'h0FFFFFF);
        check("ovf_flag", ovf, 1);
`else
        check("wrap_out", y, 32'h1C00000);
        check("wrap_flag", ovf, 0);
`endif

        // overrun and busy coefficient write
        do_reset();
        write_coef(4'd10, 18'h00000);
        d_in = 25'h0400000; dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
        tick();
        dv_in = 1'b1; d_in = 25'h0100000;
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 18'h02000;
        tick();
        dv_in = 1'b0; coef_we = 1'b0;
        pulses = 0; cap = 'x;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dv_out) begin
                pulses++;
                cap = d_out;
            end
        end
        check("ovr_pulses", pulses, 1);
        check("ovr_out", cap, 32'h0400000);
        check("ovr_flag", overrun, 1);
        send(25'h0400000, y, lat, low);
        check("ovr_coef_kept", y, 32'h0400000);
        check("ovr_sticky", overrun, 1);

        // coefficient write together with dv_in applies to that sample
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 18'h02000;
        send(25'h0400000, y, lat, low);
        coef_we = 1'b0;
        check("we_with_dv", y, 32'h0200000);

        // reset on the 5th busy cycle aborts the sample
        do_reset();
        check("rst_clears_ovr", overrun, 0);
        write_coef(4'd0, 18'h02000);
        d_in = 25'h0400000; dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", in_ready, 1);
        check("abort_dv", dv_out, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dv_out) pulses++;
        end
        check("abort_no_out", pulses, 0);
        send(25'h0400000, y, lat, low);
        check("abort_next", y, 32'h0400000);
        check("abort_latency", lat, 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
